// File: rtl/sobel_feeder_pkg.sv
// Shared types and sizing helpers for the Sobel column feeder.
package sobel_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

   localparam int DATA_W_DEF = 5;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/sobel_column_feeder_line_buffer.sv
// One image row of storage: combinational read, synchronous write, shared address.
module line_buffer
   import sobel_feeder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = DATA_W_DEF
) (
   input  logic                       clk,
   input  logic                       we_i,
   input  logic [clog2(DEPTH)-1:0]    addr_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Read returns the old word when a write hits the same address this cycle.
   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/sobel_column_feeder.sv
// Turns a raster pixel stream into registered 3-pixel vertical columns for the Sobel stage.
module sobel_column_feeder
   import sobel_feeder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] pixel_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] pixel_out0,
   output logic [DATA_W-1:0] pixel_out1,
   output logic [DATA_W-1:0] pixel_out2,
   output logic              enable,
   output logic              done,
   output logic              frame_err,
   output logic [1:0]        state_dbg
);

   localparam int XW = clog2(IMG_W);
   localparam int YW = clog2(IMG_H);

   feeder_state_t     state_q, state_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [DATA_W-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
   logic              en_q, en_d, done_q, done_d, err_q, err_d;
   logic              accept, last_x;
   logic [DATA_W-1:0] top_rd, mid_rd;

   // Handshake: a pixel transfers on a cycle where in_valid and in_ready are both high;
   // in_ready depends only on state, never on in_valid.
   assign in_ready = (state_q == FILL) || (state_q == STREAM);
   assign accept   = in_valid & in_ready;
   assign last_x   = (x_q == XW'(IMG_W - 1));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      en_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = FILL;
               x_d     = '0;
               y_d     = '0;
               err_d   = 1'b0;
            end else if (state_q == DONE) begin
               done_d = 1'b1;
            end
         end
         FILL, STREAM: begin
            // Any idle cycle while streaming breaks the continuous enable Sobel needs.
            if (state_q == STREAM && !in_valid) begin
               err_d = 1'b1;
            end
            if (accept) begin
               x_d = last_x ? '0 : x_q + XW'(1);
               if (last_x) begin
                  y_d = y_q + YW'(1);
                  if (state_q == FILL && y_q == YW'(1)) begin
                     state_d = STREAM;
                  end
                  if (state_q == STREAM && y_q == YW'(IMG_H - 1)) begin
                     state_d = DONE;
                     y_d     = '0;
                  end
               end
               if (state_q == STREAM) begin
                  en_d = 1'b1;
                  p0_d = top_rd;
                  p1_d = mid_rd;
                  p2_d = pixel_in;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         en_q    <= en_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Rows shift upward on every accept: mid moves into top, the new pixel into mid.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) lb_top (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (x_q),
      .wdata_i (mid_rd),
      .rdata_o (top_rd)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) lb_mid (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (x_q),
      .wdata_i (pixel_in),
      .rdata_o (mid_rd)
   );

   assign pixel_out0 = p0_q;
   assign pixel_out1 = p1_q;
   assign pixel_out2 = p2_q;
   assign enable     = en_q;
   assign done       = done_q;
   assign frame_err  = err_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_sobel_column_feeder.sv
// Scoreboard bench for sobel_column_feeder on a 4x4 image of 5-bit pixels.
module tb_sobel_column_feeder;

   localparam int DW   = 5;
   localparam int IW   = 4;
   localparam int IH   = 4;
   localparam int NPIX = IW * IH;
   localparam int NCOL = IW * (IH - 2);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] pixel_in = '0;
   logic          in_ready, enable, done, frame_err;
   logic [DW-1:0] pixel_out0, pixel_out1, pixel_out2;
   logic [1:0]    state_dbg;

   sobel_column_feeder #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pixel_in   (pixel_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pixel_out0 (pixel_out0),
      .pixel_out1 (pixel_out1),
      .pixel_out2 (pixel_out2),
      .enable     (enable),
      .done       (done),
      .frame_err  (frame_err),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   logic [3*DW-1:0] exp_q[$];
   logic [DW-1:0]   img [NPIX];
   int              n_cmp = 0;
   int              n_bad = 0;
   int              en_count = 0;
   int              holes = 0;
   bit              started = 1'b0;
   bit              running = 1'b1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, req);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pops one expected column per enable; counts enable-low cycles inside a started frame.
   task automatic monitor();
      logic [3*DW-1:0] e;
      while (running) begin
         @(negedge clk);
         if (enable) begin
            en_count++;
            started = 1'b1;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL column_unexpected: got %0h/%0h/%0h, want no column",
                        pixel_out0, pixel_out1, pixel_out2);
            end else begin
               e = exp_q.pop_front();
               chk("column", {pixel_out0, pixel_out1, pixel_out2}, e);
            end
         end else if (started && exp_q.size() > 0) begin
            holes++;
         end
         if (!in_ready) started = 1'b0;
      end
   endtask

   // pat: 0 -> (4y+x) mod 32, 1 -> 31-(4y+x), 2 -> random.
   task automatic run_frame(input int pat, input int drop_idx, input int start_idx,
                            input int rst_idx, input bit fill_gap, input bit rand_drop,
                            input bit start_with_valid);
      int en0, h0, drops, tries, x, y;
      bit gap;
      for (int i = 0; i < NPIX; i++) begin
         x = i % IW;
         y = i / IW;
         case (pat)
            0:       img[i] = DW'((4 * y + x) % 32);
            1:       img[i] = DW'(31 - (4 * y + x));
            default: img[i] = DW'($urandom_range(0, 31));
         endcase
      end
      start = 1'b1;
      if (start_with_valid) begin
         in_valid = 1'b1;
         pixel_in = DW'(31);
         @(negedge clk);
         chk("in_ready_with_start", in_ready, 0);
      end
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("err_cleared_on_start", frame_err, 0);
      chk("done_cleared_on_start", done, 0);
      en0   = en_count;
      h0    = holes;
      drops = 0;
      for (int i = 0; i < NPIX; i++) begin
         y   = i / IW;
         gap = (i == drop_idx) || (fill_gap && y < 2 && (i % 2) == 1) ||
               (rand_drop && i > 2 * IW && $urandom_range(0, 3) == 0);
         if (gap) begin
            in_valid = 1'b0;
            if (i > 2 * IW) drops++;
            step();
         end
         in_valid = 1'b1;
         pixel_in = img[i];
         start    = (i == start_idx);
         if (y >= 2) exp_q.push_back({img[i - 2 * IW], img[i - IW], img[i]});
         if (i == rst_idx) begin
            reset = 1'b0;
            step();
            chk("rst_enable", enable, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_done", done, 0);
            in_valid = 1'b0;
            reset    = 1'b1;
            exp_q.delete();
            step();
            return;
         end
         tries = 0;
         @(negedge clk);
         while (!in_ready && tries < 8) begin
            tries++;
            @(negedge clk);
         end
         if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 at pixel %0d, want 1", i);
         end
         step();
         start = 1'b0;
         if (i == 2 * IW - 1) chk("en_before_first", enable, 0);
         if (i == 2 * IW)     chk("first_en_latency", enable, 1);
      end
      in_valid = 1'b0;
      chk("last_col_enable", enable, 1);
      chk("done_with_last_col", done, 0);
      step();
      chk("done_after_last", done, 1);
      chk("enable_after_last", enable, 0);
      step();
      chk("done_level", done, 1);
      chk("frame_err", frame_err, (drops > 0) ? 1 : 0);
      chk("col_count", en_count - en0, NCOL);
      chk("enable_holes", holes - h0, drops);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      fork
         monitor();
         begin
            repeat (20000) @(posedge clk);
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: got 20000 cycles, want end of sequence");
         end
         begin
            repeat (3) step();
            chk("rst_in_ready0", in_ready, 0);
            chk("rst_enable0", enable, 0);
            chk("rst_done0", done, 0);
            chk("rst_err0", frame_err, 0);
            chk("rst_pix0", {pixel_out0, pixel_out1, pixel_out2}, 0);
            chk("rst_state0", state_dbg, 0);
            reset = 1'b1;
            step();
            run_frame(0, -1, -1, -1, 1'b0, 1'b0, 1'b1);
            run_frame(0, 13, -1, -1, 1'b0, 1'b0, 1'b0);
            run_frame(0, -1, -1, -1, 1'b1, 1'b0, 1'b0);
            run_frame(2, -1, -1, 10, 1'b0, 1'b0, 1'b0);
            run_frame(2, -1, 12, -1, 1'b1, 1'b0, 1'b0);
            run_frame(1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 6; k++) begin
               run_frame(2, -1, -1, -1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end
            repeat (2) step();
         end
      join_any
      running = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_column_feeder.md
Name: sobel_column_feeder

Overview:
Producer side of the Sobel column interface. Accepts a raster-order pixel stream, holds the two previous image rows in line buffers, and emits one vertical 3-pixel column per accepted pixel once row 2 is reached. It drives the Sobel block's three column-pixel inputs and its enable with exactly the timing that block requires. Sits between the image source (memory reader or testbench) and the Sobel stage of the edge-detection pipeline.

Parameters:
DATA_W, 5, pixel width; must equal the pipeline pixel width used by the Sobel stage.
IMG_W, 16, image width in pixels (>=3).
IMG_H, 16, image height in pixels (>=3).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  frame-start pulse; honoured only in IDLE or DONE
pixel_in  in  DATA_W  raster pixel, row-major, x fastest
in_valid  in  1  pixel_in valid this cycle
in_ready  out  1  feeder accepts pixel_in this cycle; accept = in_valid & in_ready
pixel_out0  out  DATA_W  column top pixel, row r-2; to Sobel pixel_in0
pixel_out1  out  DATA_W  column middle pixel, row r-1; to Sobel pixel_in1
pixel_out2  out  DATA_W  column bottom pixel, row r; to Sobel pixel_in2
enable  out  1  column valid; to Sobel enable
done  out  1  level; frame fully emitted
frame_err  out  1  sticky; enable dropped mid-frame

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, x=0, y=0, all outputs 0. Line buffer contents are don't-care.
- States: IDLE, FILL, STREAM, DONE.
- IDLE: in_ready=0. start -> FILL, x=y=0, frame_err=0, done=0.
- FILL (y=0,1): in_ready=1, enable=0. Each accepted pixel is written into the line buffers.
- On accept: x increments. At x==IMG_W-1, x wraps to 0 and y increments. When y wraps 1->2, go to STREAM.
- STREAM (y>=2): in_ready=1. When pixel p is accepted at (x,y), the next cycle presents:
  - pixel_out0 = lb_top[x]
  - pixel_out1 = lb_mid[x]
  - pixel_out2 = p
  - enable = 1
- Latency is exactly 1 cycle from accept to enable.
- Line buffer update on accept: lb_top[x] <= lb_mid[x], lb_mid[x] <= p. Read before write at the same address in the same cycle.
- Outputs are registered. enable=0 in every cycle that follows a non-accept cycle. When enable=0, pixel_out0..2 hold their last values.
- Accepting (IMG_W-1, IMG_H-1) -> DONE next cycle; the final column is presented in that cycle. done=1 from the cycle after the final column and stays high until the next start. in_ready=0 in DONE.
- Sobel contract: its enable must stay continuously high from the first to the last column, since a drop ends its operation. If in_valid=0 in any STREAM cycle before the last pixel, enable is low the following cycle, frame_err=1 (sticky until next start), and streaming continues normally.
- Idle gaps in FILL are legal and do not set frame_err.
- start in FILL or STREAM: ignored. start in DONE: new frame, same as from IDLE; the previous frame's line buffer contents are overwritten during FILL before any use.
- Simultaneous start and in_valid in IDLE/DONE: pixel not accepted (in_ready=0 that cycle).
- Reset mid-frame: immediate return to IDLE; enable=0 the next cycle; no partial column emitted.
- Expected enable cycles per frame: IMG_W*(IMG_H-2).

Decomposition:
- Package sobel_feeder_pkg holds:
  - state enum (IDLE=2'd0, FILL=2'd1, STREAM=2'd2, DONE=2'd3)
  - DATA_W default
  - counter width function clog2(IMG_W), clog2(IMG_H)
- One sub-module: line_buffer (depth IMG_W, width DATA_W, one combinational read and one synchronous write at the same address). Instantiated twice, as lb_top and lb_mid.

Test Plan:
- IMG_W=4, IMG_H=4, DATA_W=5, pixel=(4y+x) mod 32, in_valid continuous after start:
  - first enable in the cycle after accepting (0,2), with pixel_out0/1/2 = 0/4/8;
  - last column 7/11/15;
  - exactly 8 contiguous enable cycles;
  - done=1 one cycle after the last column.
- Same frame with in_valid dropped for 1 cycle before pixel (1,3):
  - enable low for exactly 1 cycle;
  - frame_err=1 and held through DONE;
  - remaining columns still correct (5/9/13 ... 7/11/15).
- FILL gaps: in_valid toggled every other cycle during rows 0-1, continuous afterwards -> frame_err=0, columns identical to the first test.
- reset=0 asserted during STREAM at pixel (2,2) -> next cycle enable=0, in_ready=0, done=0. A new start plus full frame then gives correct columns with no stale data.
- start pulsed during STREAM -> ignored, column count still 8. A second start in DONE with pixel=31-(4y+x) -> first column 31/27/23, frame_err cleared.
- start asserted together with in_valid in IDLE -> that pixel not accepted (in_ready=0). The following pixel is treated as (0,0).
